nano_sys_ctrl: RTL and testbench

Synthesizable system controller for nanoLADA single-cycle and multi-cycle systems. It sits on the nanocpu data bus beside the data memory and owns four jobs: CPU reset stretching, run-cycle counting, program exit (pass/fail) and watchdog timeout. Its 32-byte memory-mapped register window lets programs end a run by store rather than the bench relying on a fixed delay. The bench watches halted/timeout and calls $finish.

---
 rtl/nano_sys_ctrl.sv | 136 +++++++++++++
 tb/tb_nano_sys_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nano_sys_ctrl.sv
// nanoLADA system controller: CPU reset stretching, run-cycle counter, program exit and watchdog.
// Optional NANO_SYS_WRCNT_EN adds a read-only store counter at window offset 0x10.
module nano_sys_ctrl #(
  parameter int unsigned   DW             = 32,
  parameter int unsigned   AW             = 32,
  parameter logic [AW-1:0] CTRL_BASE      = AW'(32'hF000_0000),
  parameter int unsigned   RESET_CYCLES   = 4,
  parameter int unsigned   TIMEOUT_CYCLES = 500,
  parameter int unsigned   CNT_W          = 32
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic [AW-1:0] d_address,
  input  logic [DW-1:0] d_wdata,
  input  logic          mem_wr,
  output logic          sel,
  output logic [DW-1:0] d_rdata,
  output logic          cpu_nreset,
  output logic          running,
  output logic          halted,
  output logic          pass,
  output logic          timeout,
  output logic [DW-1:0] exit_code
);

  typedef enum logic [1:0] {S_RST, S_RUN, S_HALT, S_TIMEOUT} state_t;

  localparam int unsigned       RC_W    = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]   RC_INIT = RC_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam bit                WD_EN   = (TIMEOUT_CYCLES != 0);
  // Compared in a widened domain so any TIMEOUT_CYCLES/CNT_W pairing is width-safe.
  localparam logic [CNT_W+31:0] WD_LAST = (CNT_W+32)'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] R_CYCLE   = 3'd0;
  localparam logic [2:0] R_SCRATCH = 3'd1;
  localparam logic [2:0] R_EXIT    = 3'd2;
  localparam logic [2:0] R_STATUS  = 3'd3;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [DW-1:0]    scratch;
  logic [2:0]       reg_idx;
  logic             wr_en;
  logic             exit_wr;
  logic             wd_hit;
  logic             unused_addr_lsb;

  assign sel             = (d_address[AW-1:5] == CTRL_BASE[AW-1:5]);
  assign reg_idx         = d_address[4:2];
  assign wr_en           = sel && mem_wr && (state == S_RUN);
  assign exit_wr         = wr_en && (reg_idx == R_EXIT);
  assign wd_hit          = WD_EN && ({32'd0, cycle_cnt} == WD_LAST);
  assign unused_addr_lsb = ^d_address[1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= S_RST;
      rst_cnt    <= RC_INIT;
      cycle_cnt  <= '0;
      scratch    <= '0;
      exit_code  <= '0;
      cpu_nreset <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          if (rst_cnt == '0) begin
            state      <= S_RUN;
            cpu_nreset <= 1'b1;
            running    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (wr_en && (reg_idx == R_SCRATCH)) scratch <= d_wdata;
          // EXIT has priority over a watchdog expiry on the same edge.
          if (exit_wr) begin
            state      <= S_HALT;
            exit_code  <= d_wdata;
            pass       <= (d_wdata == DW'(1));
            halted     <= 1'b1;
            running    <= 1'b0;
            cpu_nreset <= 1'b0;
          end else if (wd_hit) begin
            state      <= S_TIMEOUT;
            timeout    <= 1'b1;
            pass       <= 1'b0;
            running    <= 1'b0;
            cpu_nreset <= 1'b0;
          end else if (cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        default: ;  // S_HALT and S_TIMEOUT hold until nreset
      endcase
    end
  end

`ifdef NANO_SYS_WRCNT_EN
  localparam logic [2:0] R_WRCNT = 3'd4;
  logic [CNT_W-1:0] wr_cnt;

  // Counts every CPU store while running, including stores outside the window and the EXIT store.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_cnt <= '0;
    end else if ((state == S_RUN) && mem_wr && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif

  // NOTE: the default assignment first keeps this combinational block from inferring latches.
  always_comb begin
    d_rdata = '0;
    if (sel) begin
      case (reg_idx)
        R_CYCLE:   d_rdata = DW'(cycle_cnt);
        R_SCRATCH: d_rdata = scratch;
        R_STATUS:  d_rdata = DW'({running, timeout, pass, halted});
`ifdef NANO_SYS_WRCNT_EN
        R_WRCNT:   d_rdata = DW'(wr_cnt);
`endif
        default:   d_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_sys_ctrl.sv
// Directed bench for nano_sys_ctrl: four instances share one bus, each built to exercise one configuration.
module tb_nano_sys_ctrl;

  logic        clock;
  logic        nreset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;

  logic        a_sel, a_cpu_nreset, a_running, a_halted, a_pass, a_timeout;
  logic [31:0] a_rdata, a_exit_code;
  logic        b_sel, b_cpu_nreset, b_running, b_halted, b_pass, b_timeout;
  logic [31:0] b_rdata, b_exit_code;
  logic        c_sel, c_cpu_nreset, c_running, c_halted, c_pass, c_timeout;
  logic [31:0] c_rdata, c_exit_code;
  logic        d_sel, d_cpu_nreset, d_running, d_halted, d_pass, d_timeout;
  logic [31:0] d_rdata, d_exit_code;

  int errors = 0;
  int checks = 0;

  // Default build: RESET_CYCLES=4, TIMEOUT_CYCLES=500.
  nano_sys_ctrl u_a (
    .clock(clock), .nreset(nreset), .d_address(addr), .d_wdata(wdata), .mem_wr(wr),
    .sel(a_sel), .d_rdata(a_rdata), .cpu_nreset(a_cpu_nreset), .running(a_running),
    .halted(a_halted), .pass(a_pass), .timeout(a_timeout), .exit_code(a_exit_code)
  );

  nano_sys_ctrl #(.TIMEOUT_CYCLES(10)) u_b (
    .clock(clock), .nreset(nreset), .d_address(addr), .d_wdata(wdata), .mem_wr(wr),
    .sel(b_sel), .d_rdata(b_rdata), .cpu_nreset(b_cpu_nreset), .running(b_running),
    .halted(b_halted), .pass(b_pass), .timeout(b_timeout), .exit_code(b_exit_code)
  );

  nano_sys_ctrl #(.CNT_W(4), .TIMEOUT_CYCLES(0)) u_c (
    .clock(clock), .nreset(nreset), .d_address(addr), .d_wdata(wdata), .mem_wr(wr),
    .sel(c_sel), .d_rdata(c_rdata), .cpu_nreset(c_cpu_nreset), .running(c_running),
    .halted(c_halted), .pass(c_pass), .timeout(c_timeout), .exit_code(c_exit_code)
  );

  nano_sys_ctrl #(.RESET_CYCLES(0)) u_d (
    .clock(clock), .nreset(nreset), .d_address(addr), .d_wdata(wdata), .mem_wr(wr),
    .sel(d_sel), .d_rdata(d_rdata), .cpu_nreset(d_cpu_nreset), .running(d_running),
    .halted(d_halted), .pass(d_pass), .timeout(d_timeout), .exit_code(d_exit_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic read_at(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  // Reset pulse of two clocks, then five clocks so RESET_CYCLES=4 instances are in RUN.
  task automatic run_up();
    nreset = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    tick();
    tick();
    nreset = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    nreset = 1'b0;
    wr     = 1'b0;
    addr   = 32'hF000_0000;
    wdata  = '0;

    // Reset state and reset stretching.
    tick();
    tick();
    check("rst_cpu_nreset", a_cpu_nreset, 0);
    check("rst_running", a_running, 0);
    check("rst_halted", a_halted, 0);
    check("rst_pass", a_pass, 0);
    check("rst_timeout", a_timeout, 0);
    check("rst_exit_code", a_exit_code, 0);
    check("rst_sel", a_sel, 1);
    check("rst_cycle", a_rdata, 0);
    nreset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("hold_cpu_nreset", a_cpu_nreset, 0);
      check("hold_running", a_running, 0);
      if (i == 1) begin
        check("rc0_running", d_running, 1);
        check("rc0_cpu_nreset", d_cpu_nreset, 1);
      end
    end
    tick();
    check("run_running", a_running, 1);
    check("run_cpu_nreset", a_cpu_nreset, 1);
    check("run_cycle0", a_rdata, 0);

    // SCRATCH read/write and decode.
    store(32'hF000_0004, 32'hA5A5_0001);
    read_at(32'hF000_0004);
    check("scratch_rd", a_rdata, 32'hA5A5_0001);
    check("scratch_sel", a_sel, 1);
    read_at(32'h0000_0004);
    check("outside_sel", a_sel, 0);
    check("outside_rdata", a_rdata, 0);
    store(32'h0000_0004, 32'h1234_5678);
    read_at(32'hF000_0004);
    check("scratch_kept", a_rdata, 32'hA5A5_0001);
    read_at(32'hF000_0008);
    check("exit_reads0", a_rdata, 0);
    read_at(32'hF000_0014);
    check("unused_reads0", a_rdata, 0);
    read_at(32'hF000_0000);
    check("cycle_count2", a_rdata, 2);

    // EXIT with code 1, then a reset pulse.
    store(32'hF000_0008, 32'd1);
    check("exit1_halted", a_halted, 1);
    check("exit1_pass", a_pass, 1);
    check("exit1_code", a_exit_code, 1);
    check("exit1_cpu_nreset", a_cpu_nreset, 0);
    check("exit1_running", a_running, 0);
    check("exit1_timeout", a_timeout, 0);
    read_at(32'hF000_000C);
    check("exit1_status", a_rdata, 32'h3);
    store(32'hF000_0004, 32'h0);
    read_at(32'hF000_0004);
    check("halt_wr_ignored", a_rdata, 32'hA5A5_0001);
    nreset = 1'b0;
    #1;
    check("pulse_halted", a_halted, 0);
    check("pulse_pass", a_pass, 0);
    check("pulse_exit_code", a_exit_code, 0);
    check("pulse_scratch", a_rdata, 0);
    check("pulse_cpu_nreset", a_cpu_nreset, 0);
    tick();
    tick();
    nreset = 1'b1;
    repeat (4) tick();
    check("restart_hold", a_running, 0);
    tick();
    check("restart_running", a_running, 1);

    // EXIT with a non-pass code.
    store(32'hF000_0008, 32'h2A);
    check("exit2a_halted", a_halted, 1);
    check("exit2a_pass", a_pass, 0);
    check("exit2a_code", a_exit_code, 32'h2A);
    read_at(32'hF000_000C);
    check("exit2a_status", a_rdata, 32'h1);

    // Watchdog with TIMEOUT_CYCLES=10.
    run_up();
    addr = 32'hF000_0000;
    check("wd_running", b_running, 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("wd_not_yet", b_timeout, 0);
    end
    check("wd_cycle9", b_rdata, 9);
    tick();
    check("wd_timeout", b_timeout, 1);
    check("wd_running_off", b_running, 0);
    check("wd_halted", b_halted, 0);
    check("wd_pass", b_pass, 0);
    check("wd_cpu_nreset", b_cpu_nreset, 0);
    repeat (3) tick();
    check("wd_cycle_frozen", b_rdata, 9);
    read_at(32'hF000_000C);
    check("wd_status", b_rdata, 32'h4);

    // EXIT on the watchdog cycle wins.
    run_up();
    repeat (9) tick();
    store(32'hF000_0008, 32'd1);
    check("race_halted", b_halted, 1);
    check("race_timeout", b_timeout, 0);
    check("race_pass", b_pass, 1);

    // CNT_W=4 saturation and store counting.
    run_up();
    store(32'h0000_0100, 32'h0);
    store(32'h0000_0100, 32'h0);
    store(32'h0000_0100, 32'h0);
    repeat (11) tick();
    read_at(32'hF000_0000);
    check("sat_cycle14", c_rdata, 14);
    repeat (6) tick();
    check("sat_cycle15", c_rdata, 15);
    check("sat_timeout", c_timeout, 0);
    check("sat_running", c_running, 1);
    read_at(32'hF000_0010);
`ifdef NANO_SYS_WRCNT_EN
    check("wrcnt", c_rdata, 3);
`else
    check("wrcnt_absent", c_rdata, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
